// File: rtl/fsm_burst_scheduler.sv
// fsm_burst_scheduler: round-robin arbiter that gives each requester a clear/run/capture burst on one shared FSM
module fsm_burst_scheduler #(
   parameter int N = 4,
   parameter int LW = 4,
   parameter int ZW = 4,
   localparam int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    req_w,
   input  logic [N*LW-1:0] req_len,
   output logic [N-1:0]    gnt,
   output logic            busy,
   output logic            fsm_reset,
   output logic            fsm_w,
   input  logic [ZW-1:0]   fsm_z,
   output logic            done,
   output logic [IW-1:0]   done_id,
   output logic [ZW-1:0]   result
);
   typedef enum logic [1:0] {IDLE, CLEAR, RUN, CAPTURE} state_t;
   state_t        state;
   logic [IW-1:0] ptr, id, pick;
   logic [LW-1:0] cnt;
   // scanning downward lets the lowest offset from ptr win
   always_comb begin
      pick = ptr;
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % N]) pick = IW'((int'(ptr) + k) % N);
   end
   assign busy      = state != IDLE;
   assign fsm_reset = reset | (state == CLEAR);
   assign fsm_w     = (state == RUN) & req_w[id];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         id      <= '0;
         cnt     <= '0;
         gnt     <= '0;
         done    <= 1'b0;
         done_id <= '0;
         result  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (|req) begin
               id    <= pick;
               cnt   <= req_len[int'(pick)*LW +: LW];
               gnt   <= N'(1) << pick;
               state <= CLEAR;
            end
            CLEAR: state <= (cnt != '0) ? RUN : CAPTURE;
            RUN: begin
               cnt <= cnt - 1'b1;
               if (cnt == LW'(1)) state <= CAPTURE;
            end
            CAPTURE: begin
               result  <= fsm_z;
               done_id <= id;
               done    <= 1'b1;
               gnt     <= '0;
               ptr     <= (id == IW'(N - 1)) ? '0 : id + 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fsm_burst_scheduler.sv
// tb_fsm_burst_scheduler: directed bench with a counting FSM model (z = ones seen since clear)
module tb_fsm_burst_scheduler;
   localparam int N = 4;
   localparam int LW = 4;
   localparam int ZW = 4;
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  req_w = '0;
   logic [N*LW-1:0] req_len = '0;
   logic [N-1:0]  gnt;
   logic          busy, fsm_reset, fsm_w, done;
   logic [1:0]    done_id;
   logic [ZW-1:0] result;
   logic [ZW-1:0] z;
   int checks = 0;
   int errors = 0;

   fsm_burst_scheduler #(.N(N), .LW(LW), .ZW(ZW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_w(req_w), .req_len(req_len),
      .gnt(gnt), .busy(busy), .fsm_reset(fsm_reset), .fsm_w(fsm_w), .fsm_z(z),
      .done(done), .done_id(done_id), .result(result)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) z <= fsm_reset ? '0 : z + ZW'(fsm_w);

   always @(negedge clk) begin
      checks++;
      if (!$onehot0(gnt) || (fsm_w && gnt == '0)) begin
         errors++;
         $display("FAIL gnt_onehot gnt=%b fsm_w=%b", gnt, fsm_w);
      end
   end

   task automatic apply_reset;
      @(negedge clk);
      reset = 1'b1;
      req = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #1;
      checks++; if (gnt !== 4'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctrl gnt=%b busy=%b done=%b exp 0", gnt, busy, done); end
      checks++; if (done_id !== 2'd0 || result !== 4'd0) begin errors++; $display("FAIL reset_data done_id=%0d result=%0d exp 0", done_id, result); end
      checks++; if (fsm_w !== 1'b0 || fsm_reset !== 1'b1) begin errors++; $display("FAIL reset_fsm fsm_w=%b fsm_reset=%b exp 0/1", fsm_w, fsm_reset); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (fsm_reset !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_release fsm_reset=%b busy=%b exp 0", fsm_reset, busy); end
   endtask

   task automatic test_single;
      int t;
      req_len = 16'h0003;
      req_w = 4'b0001;
      req = 4'b0001;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
      checks++; if (fsm_reset !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_clear fsm_reset=%b busy=%b exp 1", fsm_reset, busy); end
      @(negedge clk);
      checks++; if (fsm_reset !== 1'b0 || fsm_w !== 1'b1) begin errors++; $display("FAIL single_run fsm_reset=%b fsm_w=%b exp 0/1", fsm_reset, fsm_w); end
      t = 1;
      while (done !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      req = '0;
      checks++; if (t !== 5) begin errors++; $display("FAIL single_latency got=%0d exp=5", t); end
      checks++; if (result !== 4'd3 || done_id !== 2'd0) begin errors++; $display("FAIL single_result result=%0d id=%0d exp 3/0", result, done_id); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || gnt !== 4'b0) begin errors++; $display("FAIL single_after done=%b gnt=%b exp 0", done, gnt); end
   endtask

   task automatic test_round_robin;
      int ord[5] = '{0, 1, 2, 3, 0};
      int g, d, last;
      logic [N-1:0] pg;
      apply_reset();
      g = 0; d = 0; last = 0; pg = '0;
      req_len = 16'h1111;
      req_w = 4'hF;
      req = 4'hF;
      for (int c = 0; c < 40 && g < 5; c++) begin
         @(negedge clk);
         if (done) begin
            checks++; if (result !== 4'd1 || done_id !== 2'(ord[d])) begin errors++; $display("FAIL rr_done result=%0d id=%0d exp 1/%0d", result, done_id, ord[d]); end
            d++;
         end
         if (gnt !== '0 && pg === '0) begin
            checks++; if (gnt !== 4'(1 << ord[g])) begin errors++; $display("FAIL rr_order grant#%0d got=%b exp_id=%0d", g, gnt, ord[g]); end
            if (g > 0) begin
               checks++; if (c - last !== 4) begin errors++; $display("FAIL rr_spacing got=%0d exp=4", c - last); end
            end
            last = c;
            g++;
         end
         pg = gnt;
      end
      req = '0;
      checks++; if (g !== 5) begin errors++; $display("FAIL rr_count got=%0d exp=5", g); end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_drop;
      logic [3:0] pat = 4'b1101;
      int t;
      req_len = 16'hFFF4;
      req_w = 4'b1110;
      req = 4'b0001;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL drop_gnt got=%b exp=0001", gnt); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_w = {{3{~pat[i]}}, pat[i]};
         if (i == 2) req = '0;
         #1;
         checks++; if (fsm_w !== pat[i]) begin errors++; $display("FAIL drop_fsm_w cycle=%0d got=%b exp=%b", i, fsm_w, pat[i]); end
      end
      t = 0;
      while (done !== 1'b1 && t < 10) begin @(negedge clk); t++; end
      req_w = '0;
      checks++; if (t !== 2) begin errors++; $display("FAIL drop_latency got=%0d exp=2", t); end
      checks++; if (result !== 4'd3 || done_id !== 2'd0) begin errors++; $display("FAIL drop_result result=%0d id=%0d exp 3/0", result, done_id); end
      @(negedge clk);
   endtask

   task automatic test_zero_len;
      int t;
      logic w_seen;
      w_seen = 1'b0;
      req_len = 16'hF0FF;
      req_w = 4'hF;
      req = 4'b0100;
      @(negedge clk);
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL zero_gnt got=%b exp=0100", gnt); end
      w_seen = fsm_w;
      t = 0;
      while (done !== 1'b1 && t < 10) begin @(negedge clk); w_seen |= fsm_w; t++; end
      req = '0;
      req_w = '0;
      checks++; if (t !== 2) begin errors++; $display("FAIL zero_latency got=%0d exp=2", t); end
      checks++; if (result !== 4'd0 || done_id !== 2'd2) begin errors++; $display("FAIL zero_result result=%0d id=%0d exp 0/2", result, done_id); end
      checks++; if (w_seen !== 1'b0) begin errors++; $display("FAIL zero_fsm_w got=%b exp=0", w_seen); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int t;
      req_len = 16'h0600;
      req_w = 4'hF;
      req = 4'b0100;
      @(negedge clk);
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt got=%b exp=0100", gnt); end
      repeat (2) @(negedge clk);
      checks++; if (fsm_w !== 1'b1) begin errors++; $display("FAIL mid_run fsm_w=%b exp=1", fsm_w); end
      reset = 1'b1;
      req = '0;
      #1;
      checks++; if (gnt !== 4'b0 || fsm_reset !== 1'b1) begin errors++; $display("FAIL mid_abort gnt=%b fsm_reset=%b exp 0/1", gnt, fsm_reset); end
      checks++; if (busy !== 1'b0 || fsm_w !== 1'b0) begin errors++; $display("FAIL mid_idle busy=%b fsm_w=%b exp 0", busy, fsm_w); end
      @(negedge clk);
      reset = 1'b0;
      req_len = 16'h0000;
      req = 4'b1010;
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_ptr got=%b exp=0010", gnt); end
      req = '0;
      t = 0;
      while (done !== 1'b1 && t < 10) begin @(negedge clk); t++; end
      checks++; if (t !== 2 || done_id !== 2'd1) begin errors++; $display("FAIL mid_next t=%0d id=%0d exp 2/1", t, done_id); end
      @(negedge clk);
   endtask

   task automatic test_alternate;
      int ord[4] = '{1, 3, 1, 3};
      int g, last;
      logic [N-1:0] pg;
      apply_reset();
      g = 0; last = 0; pg = '0;
      req_len = 16'h1111;
      req_w = '0;
      req = 4'b1010;
      for (int c = 0; c < 40 && g < 4; c++) begin
         @(negedge clk);
         if (gnt !== '0 && pg === '0) begin
            checks++; if (gnt !== 4'(1 << ord[g])) begin errors++; $display("FAIL alt_order grant#%0d got=%b exp_id=%0d", g, gnt, ord[g]); end
            if (g > 0) begin
               checks++; if (c - last !== 4) begin errors++; $display("FAIL alt_spacing got=%0d exp=4", c - last); end
            end
            last = c;
            g++;
         end
         pg = gnt;
      end
      req = '0;
      checks++; if (g !== 4) begin errors++; $display("FAIL alt_count got=%0d exp=4", g); end
      repeat (6) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_drop();
      test_zero_len();
      test_reset_mid();
      test_alternate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
